// File: rtl/imu_sample_assembler_pkg.sv
// rtl/imu_sample_assembler_pkg.sv - shared widths, frame constants, FSM states and sample type
// Purpose: constants and types shared by the IMU sample assembler and its
//          output register. ACC_WIDTH/GYRO_WIDTH match the filter core inputs.
// Ports:   none (package).
package imu_sample_assembler_pkg;

  localparam int ACC_WIDTH       = 24;
  localparam int GYRO_WIDTH      = 20;
  localparam int IMU_FRAME_BYTES = 12;
  localparam int IMU_RAW_WIDTH   = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } imu_state_e;

  typedef struct packed {
    logic signed [ACC_WIDTH-1:0]  a_x;
    logic signed [ACC_WIDTH-1:0]  a_y;
    logic signed [ACC_WIDTH-1:0]  a_z;
    logic signed [GYRO_WIDTH-1:0] w_x;
    logic signed [GYRO_WIDTH-1:0] w_y;
    logic signed [GYRO_WIDTH-1:0] w_z;
  } imu_sample_t;

  function automatic logic signed [ACC_WIDTH-1:0] sext_acc(input logic [IMU_RAW_WIDTH-1:0] raw);
    return {{(ACC_WIDTH-IMU_RAW_WIDTH){raw[IMU_RAW_WIDTH-1]}}, raw};
  endfunction

  function automatic logic signed [GYRO_WIDTH-1:0] sext_gyro(input logic [IMU_RAW_WIDTH-1:0] raw);
    return {{(GYRO_WIDTH-IMU_RAW_WIDTH){raw[IMU_RAW_WIDTH-1]}}, raw};
  endfunction

endpackage

// File: rtl/imu_out_reg.sv
// rtl/imu_out_reg.sv - single-entry valid/ready sample register with overrun counter
// Purpose: holds one assembled sample for the downstream consumer. A new
//          sample is loaded when the slot is empty or being drained in the
//          same cycle; otherwise it is dropped and counted as an overrun.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          a complete sample is offered this cycle
//   sample_i        the offered sample
//   ready_i         downstream accepts the held sample
//   valid_o         a sample is held
//   sample_o        held sample, stable while valid_o && !ready_i
//   overrun_cnt_o   saturating count of dropped samples
module imu_out_reg
  import imu_sample_assembler_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  imu_sample_t          sample_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output imu_sample_t          sample_o,
  output logic [CNT_WIDTH-1:0] overrun_cnt_o
);

  logic                 valid_q, valid_d;
  imu_sample_t          sample_q, sample_d;
  logic [CNT_WIDTH-1:0] ovr_q, ovr_d;
  logic                 slot_free;

  // The slot counts as free when it is being drained this cycle, so a
  // back-to-back reload keeps valid high with no bubble.
  always_comb begin
    valid_d   = valid_q;
    sample_d  = sample_q;
    ovr_d     = ovr_q;
    slot_free = !valid_q || ready_i;
    if (load_i && slot_free) begin
      valid_d  = 1'b1;
      sample_d = sample_i;
    end else begin
      if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
      if (load_i && (ovr_q != {CNT_WIDTH{1'b1}})) begin
        ovr_d = ovr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      sample_q <= '0;
      ovr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      sample_q <= sample_d;
      ovr_q    <= ovr_d;
    end
  end

  assign valid_o       = valid_q;
  assign sample_o      = sample_q;
  assign overrun_cnt_o = ovr_q;

endmodule

// File: rtl/imu_sample_assembler.sv
// rtl/imu_sample_assembler.sv - IMU burst byte stream to 6-axis signed sample
// Purpose: collects 12-byte big-endian frames (ax ay az wx wy wz), sign-extends
//          each axis and hands the sample to the filter through a single-entry
//          valid/ready register. Counts aborted frames and dropped frames.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   byte_valid        byte_data valid (always consumed, no backpressure)
//   byte_data         stream byte
//   byte_sof          with byte_valid: first byte of a frame
//   valid_out         sample held for downstream
//   ready_out         downstream accepts the sample
//   a_x, a_y, a_z     signed accel, ACC_WIDTH bits
//   w_x, w_y, w_z     signed gyro, GYRO_WIDTH bits
//   frame_err_cnt     saturating count of frames aborted by a new sof
//   overrun_cnt       saturating count of complete frames dropped
module imu_sample_assembler
  import imu_sample_assembler_pkg::*;
#(
  parameter int RAW_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  input  logic                         byte_sof,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic signed [ACC_WIDTH-1:0]  a_x,
  output logic signed [ACC_WIDTH-1:0]  a_y,
  output logic signed [ACC_WIDTH-1:0]  a_z,
  output logic signed [GYRO_WIDTH-1:0] w_x,
  output logic signed [GYRO_WIDTH-1:0] w_y,
  output logic signed [GYRO_WIDTH-1:0] w_z,
  output logic [CNT_WIDTH-1:0]         frame_err_cnt,
  output logic [CNT_WIDTH-1:0]         overrun_cnt
);

  localparam int                 IDX_W    = $clog2(IMU_FRAME_BYTES);
  localparam int                 ASM_N    = IMU_FRAME_BYTES - 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(IMU_FRAME_BYTES - 1);

  imu_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  // The last byte is never stored: it is used directly in the completion cycle.
  logic [7:0]           asm_q [ASM_N];
  logic [7:0]           asm_d [ASM_N];
  logic [CNT_WIDTH-1:0] ferr_q, ferr_d;
  logic                 frame_done;

  logic [RAW_WIDTH-1:0] raw_w [6];
  imu_sample_t          sample_new;
  imu_sample_t          sample_held;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (byte_valid && byte_sof) begin
          asm_d[0] = byte_data;
          idx_d    = IDX_W'(1);
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          if (byte_sof) begin
            // Resync: abandon the partial frame and restart from this byte.
            if (ferr_q != {CNT_WIDTH{1'b1}}) begin
              ferr_d = ferr_q + 1'b1;
            end
            asm_d[0] = byte_data;
            idx_d    = IDX_W'(1);
          end else if (idx_q == LAST_IDX) begin
            frame_done = 1'b1;
            idx_d      = '0;
            state_d    = IDLE;
          end else begin
            for (int i = 0; i < ASM_N; i++) begin
              if (idx_q == IDX_W'(i)) begin
                asm_d[i] = byte_data;
              end
            end
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ferr_q  <= '0;
      for (int i = 0; i < ASM_N; i++) begin
        asm_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ferr_q  <= ferr_d;
      asm_q   <= asm_d;
    end
  end

  // Big-endian axis words; the final low byte comes straight from the stream.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      raw_w[k] = {asm_q[2*k], asm_q[2*k+1]};
    end
    raw_w[5] = {asm_q[10], byte_data};
  end

  always_comb begin
    sample_new     = '0;
    sample_new.a_x = sext_acc(raw_w[0]);
    sample_new.a_y = sext_acc(raw_w[1]);
    sample_new.a_z = sext_acc(raw_w[2]);
    sample_new.w_x = sext_gyro(raw_w[3]);
    sample_new.w_y = sext_gyro(raw_w[4]);
    sample_new.w_z = sext_gyro(raw_w[5]);
  end

  imu_out_reg #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (frame_done),
    .sample_i      (sample_new),
    .ready_i       (ready_out),
    .valid_o       (valid_out),
    .sample_o      (sample_held),
    .overrun_cnt_o (overrun_cnt)
  );

  assign a_x           = sample_held.a_x;
  assign a_y           = sample_held.a_y;
  assign a_z           = sample_held.a_z;
  assign w_x           = sample_held.w_x;
  assign w_y           = sample_held.w_y;
  assign w_z           = sample_held.w_z;
  assign frame_err_cnt = ferr_q;

endmodule

// File: tb/tb_imu_sample_assembler.sv
// tb/tb_imu_sample_assembler.sv - randomized self-checking bench for imu_sample_assembler
module tb_imu_sample_assembler;
  import imu_sample_assembler_pkg::*;

  logic                         clk;
  logic                         rst_n;
  logic                         byte_valid;
  logic [7:0]                   byte_data;
  logic                         byte_sof;
  logic                         valid_out;
  logic                         ready_out;
  logic signed [ACC_WIDTH-1:0]  a_x, a_y, a_z;
  logic signed [GYRO_WIDTH-1:0] w_x, w_y, w_z;
  logic [7:0]                   frame_err_cnt;
  logic [7:0]                   overrun_cnt;

  imu_sample_assembler #(
    .RAW_WIDTH (16),
    .CNT_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_sof      (byte_sof),
    .valid_out     (valid_out),
    .ready_out     (ready_out),
    .a_x           (a_x),
    .a_y           (a_y),
    .a_z           (a_z),
    .w_x           (w_x),
    .w_y           (w_y),
    .w_z           (w_z),
    .frame_err_cnt (frame_err_cnt),
    .overrun_cnt   (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  // Reference model: bytes of the frame in progress, the held sample and counters.
  logic [7:0] fq [$];
  bit         m_valid;
  int         m_s [6];
  int         m_ferr;
  int         m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, $signed(obs), obs,
               $signed(exp_v), exp_v, $time);
    end
  endtask

  function automatic int word16(input logic [7:0] hi, input logic [7:0] lo);
    logic signed [15:0] w;
    w = {hi, lo};
    return int'(w);
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_clear();
    fq.delete();
    m_valid = 1'b0;
    m_ferr  = 0;
    m_ovr   = 0;
    for (int k = 0; k < 6; k++) m_s[k] = 0;
  endtask

  task automatic model_step(input bit bv, input logic [7:0] bd, input bit sof, input bit rdy);
    bit done;
    int ns [6];
    done = 1'b0;
    for (int k = 0; k < 6; k++) ns[k] = 0;
    if (bv) begin
      if (sof) begin
        if (fq.size() != 0) m_ferr = sat255(m_ferr + 1);
        fq.delete();
        fq.push_back(bd);
      end else if (fq.size() != 0) begin
        fq.push_back(bd);
        if (fq.size() == 12) begin
          done = 1'b1;
          for (int k = 0; k < 6; k++) ns[k] = word16(fq[2*k], fq[2*k+1]);
          fq.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_s     = ns;
      end else begin
        m_ovr = sat255(m_ovr + 1);
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    check_eq("valid_out", 32'(valid_out), 32'(m_valid));
    check_eq("frame_err_cnt", 32'(frame_err_cnt), m_ferr);
    check_eq("overrun_cnt", 32'(overrun_cnt), m_ovr);
    if (m_valid) begin
      check_eq("a_x", int'(a_x), m_s[0]);
      check_eq("a_y", int'(a_y), m_s[1]);
      check_eq("a_z", int'(a_z), m_s[2]);
      check_eq("w_x", int'(w_x), m_s[3]);
      check_eq("w_y", int'(w_y), m_s[4]);
      check_eq("w_z", int'(w_z), m_s[5]);
    end
  endtask

  // One clock: drive at the falling edge, compare at the next falling edge.
  task automatic cycle(input bit bv, input logic [7:0] bd, input bit sof, input bit rdy);
    byte_valid = bv;
    byte_data  = bd;
    byte_sof   = sof;
    ready_out  = rdy;
    if (valid_out && rdy) xfers++;
    model_step(bv, bd, sof, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic send_frame(input logic [7:0] b [12], input bit rdy, input bit rdy_last);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, b[i], i == 0, (i == 11) ? rdy_last : rdy);
    end
  endtask

  task automatic rand_frame(output logic [7:0] b [12]);
    for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
  endtask

  task automatic do_reset(input string tag);
    byte_valid = 1'b0;
    byte_sof   = 1'b0;
    rst_n      = 1'b0;
    #2;
    check_eq({tag, "_valid"}, 32'(valid_out), 0);
    check_eq({tag, "_ax"}, int'(a_x), 0);
    check_eq({tag, "_wz"}, int'(w_z), 0);
    check_eq({tag, "_ferr"}, 32'(frame_err_cnt), 0);
    check_eq({tag, "_ovr"}, 32'(overrun_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1 [12];
    logic [7:0] fa [12];
    logic [7:0] fb [12];
    int         x0;
    bit         bv, sof;

    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_sof   = 1'b0;
    ready_out  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset("init");

    // Known-value frame with ready held high.
    f1 = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h40, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hF0, 8'h7F, 8'hFF};
    send_frame(f1, 1'b1, 1'b1);
    check_eq("t1_valid", 32'(valid_out), 1);
    check_eq("t1_ax", int'(a_x), 256);
    check_eq("t1_ay", int'(a_y), -256);
    check_eq("t1_az", int'(a_z), 16384);
    check_eq("t1_wx", int'(w_x), 16);
    check_eq("t1_wy", int'(w_y), -16);
    check_eq("t1_wz", int'(w_z), 32767);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t1_drop", 32'(valid_out), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Back-pressure: second frame is dropped, first is held then delivered once.
    do_reset("bp_rst");
    rand_frame(fa);
    rand_frame(fb);
    fb[0] = ~fa[0];
    send_frame(fa, 1'b0, 1'b0);
    send_frame(fb, 1'b0, 1'b0);
    check_eq("bp_ovr", 32'(overrun_cnt), 1);
    check_eq("bp_ax_held", int'(a_x), word16(fa[0], fa[1]));
    x0 = xfers;
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("bp_one_xfer", xfers - x0, 1);

    // Release in the same cycle the next frame completes.
    do_reset("sim_rst");
    rand_frame(fa);
    rand_frame(fb);
    fb[0] = ~fa[0];
    send_frame(fa, 1'b0, 1'b0);
    x0 = xfers;
    send_frame(fb, 1'b0, 1'b1);
    check_eq("sim_valid", 32'(valid_out), 1);
    check_eq("sim_xfer", xfers - x0, 1);
    check_eq("sim_ax", int'(a_x), word16(fb[0], fb[1]));
    check_eq("sim_ovr", 32'(overrun_cnt), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Resync: sof plus 5 bytes, then a full frame.
    do_reset("rs_rst");
    cycle(1'b1, 8'hAA, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
    rand_frame(fa);
    send_frame(fa, 1'b1, 1'b1);
    check_eq("rs_ferr", 32'(frame_err_cnt), 1);
    check_eq("rs_wz", int'(w_z), word16(fa[10], fa[11]));

    // Garbage before sof is ignored silently.
    do_reset("gb_rst");
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    rand_frame(fa);
    send_frame(fa, 1'b1, 1'b1);
    check_eq("gb_ferr", 32'(frame_err_cnt), 0);
    check_eq("gb_ay", int'(a_y), word16(fa[2], fa[3]));

    // Reset mid-frame, then a clean frame.
    do_reset("mf_rst0");
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    do_reset("mf_rst");
    rand_frame(fa);
    send_frame(fa, 1'b1, 1'b1);
    check_eq("mf_ferr", 32'(frame_err_cnt), 0);
    check_eq("mf_wx", int'(w_x), word16(fa[6], fa[7]));

    // Random stream with random backpressure against the model.
    do_reset("rnd_rst");
    for (int n = 0; n < 2000; n++) begin
      bv  = ($urandom_range(0, 3) != 0);
      sof = bv && ($urandom_range(0, 13) == 0);
      cycle(bv, 8'($urandom), sof, 1'($urandom_range(0, 1)));
    end

    // Overrun counter saturation.
    do_reset("sat_rst");
    rand_frame(fa);
    send_frame(fa, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) send_frame(fa, 1'b0, 1'b0);
    check_eq("sat_ovr", 32'(overrun_cnt), 255);
    check_eq("sat_valid", 32'(valid_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
